compressed_line_packer: RTL and testbench

Downstream bit packer for the compression path. Accepts variable-length compressed codes, one per beat, LSB-aligned. Concatenates them LSB-first into one CACHE_LINE-bit packed line and presents the finished line with a valid/ready handshake to the line store. Flags lines whose compressed size exceeds CACHE_LINE so the store can keep the line uncompressed.

---
 rtl/compress_pkg.sv | 28 ++
 rtl/packer_shift_merge.sv | 28 ++
 rtl/compressed_line_packer.sv | 102 ++++++++++
 tb/tb_compressed_line_packer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/compress_pkg.sv
// Shared constants, FSM state type and word-count helper for the
// compression-path line packer.
package compress_pkg;

  localparam int CACHE_LINE = 128;
  localparam int WORD_SIZE  = 64;
  localparam int MAX_CODE   = 68;
  localparam int LEN_W      = 7;
  // Bit count must hold CACHE_LINE + MAX_CODE without wrapping.
  localparam int CNT_W      = 8;

  typedef enum logic [1:0] {
    ACCUM,
    DISCARD,
    HOLD
  } packer_state_t;

  function automatic logic [1:0] words_for_bits(input logic [CNT_W-1:0] bits);
    if (bits == '0) begin
      return 2'd0;
    end else if (bits <= CNT_W'(WORD_SIZE)) begin
      return 2'd1;
    end else begin
      return 2'd2;
    end
  endfunction

endpackage

// File: rtl/packer_shift_merge.sv
// Barrel-shift merge: masks a code to its length, shifts it to the current
// fill point and ORs it into the line; also returns the new fill count.
module packer_shift_merge
  import compress_pkg::*;
(
  input  logic [CACHE_LINE-1:0] line_i,
  input  logic [CNT_W-1:0]      cnt_i,
  input  logic [MAX_CODE-1:0]   data_i,
  input  logic [LEN_W-1:0]      len_i,
  output logic [CACHE_LINE-1:0] merged_o,
  output logic [CNT_W-1:0]      nxt_o
);

  logic [MAX_CODE-1:0]   mask;
  logic [CACHE_LINE-1:0] code_wide;

  always_comb begin
    for (int i = 0; i < MAX_CODE; i++) begin
      mask[i] = (i < int'(len_i));
    end
  end

  assign code_wide = {{(CACHE_LINE - MAX_CODE){1'b0}}, data_i & mask};
  // Only meaningful when nxt_o fits; bits shifted past the top simply fall off.
  assign merged_o  = line_i | (code_wide << cnt_i);
  assign nxt_o     = cnt_i + {1'b0, len_i};

endmodule

// File: rtl/compressed_line_packer.sv
// Packs variable-length codes LSB-first into one cache line and hands the
// finished line, with its size and overflow flag, to the line store.
module compressed_line_packer
  import compress_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_valid,
  input  logic [MAX_CODE-1:0]   i_data,
  input  logic [LEN_W-1:0]      i_length,
  input  logic                  i_last,
  output logic                  o_ready,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [CACHE_LINE-1:0] o_line,
  output logic [7:0]            o_line_bits,
  output logic [1:0]            o_word_count,
  output logic                  o_overflow
);

  packer_state_t         state_q, state_d;
  logic [CACHE_LINE-1:0] line_q, line_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;

  logic [CACHE_LINE-1:0] merged;
  logic [CNT_W-1:0]      nxt;
  logic                  accept;
  logic                  holding;

  packer_shift_merge u_shift_merge (
    .line_i   (line_q),
    .cnt_i    (cnt_q),
    .data_i   (i_data),
    .len_i    (i_length),
    .merged_o (merged),
    .nxt_o    (nxt)
  );

  assign holding = (state_q == HOLD);
  assign o_ready = !holding;
  assign accept  = i_valid && o_ready;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path infers a latch.
    state_d = state_q;
    line_d  = line_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      ACCUM: begin
        if (accept) begin
          if (nxt <= CNT_W'(CACHE_LINE)) begin
            line_d  = merged;
            cnt_d   = nxt;
            state_d = i_last ? HOLD : ACCUM;
          end else begin
            // Line no longer fits: keep what we have, drop the rest of the line.
            ovf_d   = 1'b1;
            state_d = i_last ? HOLD : DISCARD;
          end
        end
      end
      DISCARD: begin
        if (accept && i_last) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (i_ready) begin
          line_d  = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // NOTE: synchronous active-high reset; state uses non-blocking assignments only.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ACCUM;
      line_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign o_valid      = holding;
  assign o_line       = holding ? line_q : '0;
  assign o_line_bits  = holding ? cnt_q : '0;
  assign o_word_count = holding ? words_for_bits(cnt_q) : 2'd0;
  assign o_overflow   = holding && ovf_q;

endmodule

// File: tb/tb_compressed_line_packer.sv
// Directed self-checking bench for compressed_line_packer with
// hand-computed expected lines, sizes and flags.
module tb_compressed_line_packer;
  import compress_pkg::*;

  logic                  i_clk = 1'b0;
  logic                  i_reset;
  logic                  i_valid;
  logic [MAX_CODE-1:0]   i_data;
  logic [LEN_W-1:0]      i_length;
  logic                  i_last;
  logic                  o_ready;
  logic                  o_valid;
  logic                  i_ready;
  logic [CACHE_LINE-1:0] o_line;
  logic [7:0]            o_line_bits;
  logic [1:0]            o_word_count;
  logic                  o_overflow;

  int errors = 0;
  int checks = 0;

  compressed_line_packer dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_valid      (i_valid),
    .i_data       (i_data),
    .i_length     (i_length),
    .i_last       (i_last),
    .o_ready      (o_ready),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_line       (o_line),
    .o_line_bits  (o_line_bits),
    .o_word_count (o_word_count),
    .o_overflow   (o_overflow)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) begin
    if (i_valid && !i_reset) begin
      assert (i_length <= LEN_W'(MAX_CODE))
        else $error("illegal i_length %0d", i_length);
    end
  end

  task automatic check(input string tag, input logic [CACHE_LINE-1:0] got,
                       input logic [CACHE_LINE-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present one beat after a rising edge and hold it until accepted.
  task automatic beat(input logic [MAX_CODE-1:0] data, input int len, input logic last);
    bit taken = 0;
    i_valid  = 1'b1;
    i_data   = data;
    i_length = LEN_W'(len);
    i_last   = last;
    for (int c = 0; c < 20 && !taken; c++) begin
      @(negedge i_clk);
      if (o_ready) taken = 1;
      @(posedge i_clk);
      #1;
    end
    if (!taken) check("beat_accept_timeout", 0, 1);
    i_valid = 1'b0;
    i_last  = 1'b0;
  endtask

  // Sample the held line on the next falling edge and compare everything.
  task automatic expect_line(input string tag, input logic [CACHE_LINE-1:0] line,
                             input int bits, input int wc, input logic ovf);
    @(negedge i_clk);
    check({tag, "_valid"}, CACHE_LINE'(o_valid), 1);
    check({tag, "_line"}, o_line, line);
    check({tag, "_bits"}, CACHE_LINE'(o_line_bits), CACHE_LINE'(bits));
    check({tag, "_wc"}, CACHE_LINE'(o_word_count), CACHE_LINE'(wc));
    check({tag, "_ovf"}, CACHE_LINE'(o_overflow), CACHE_LINE'(ovf));
  endtask

  task automatic take_line(input string tag);
    @(posedge i_clk);
    #1 i_ready = 1'b1;
    @(posedge i_clk);
    #1 i_ready = 1'b0;
    @(negedge i_clk);
    check({tag, "_valid_drop"}, CACHE_LINE'(o_valid), 0);
    check({tag, "_ready_back"}, CACHE_LINE'(o_ready), 1);
  endtask

  logic [CACHE_LINE-1:0] held;

  initial begin
    i_reset  = 1'b1;
    i_valid  = 1'b1;
    i_data   = '1;
    i_length = LEN_W'(MAX_CODE);
    i_last   = 1'b1;
    i_ready  = 1'b0;

    // 1: reset held two cycles with a beat offered
    repeat (2) @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    i_valid = 1'b0;
    i_last  = 1'b0;
    @(negedge i_clk);
    check("rst_valid", CACHE_LINE'(o_valid), 0);
    check("rst_line", o_line, 0);
    check("rst_bits", CACHE_LINE'(o_line_bits), 0);
    check("rst_wc", CACHE_LINE'(o_word_count), 0);
    check("rst_ovf", CACHE_LINE'(o_overflow), 0);
    check("rst_ready", CACHE_LINE'(o_ready), 1);
    @(posedge i_clk);
    #1;

    // 2: 34+34+34+26 = exactly 128 bits, not an overflow
    beat('1, 34, 0);
    beat('1, 34, 0);
    beat('1, 34, 0);
    beat('1, 26, 1);
    expect_line("full", {CACHE_LINE{1'b1}}, 128, 2, 0);
    check("full_ready_low", CACHE_LINE'(o_ready), 0);
    take_line("full");

    // 3: garbage above i_length must be masked; 01 then 110 -> 11001
    @(posedge i_clk);
    #1;
    beat(68'hF_FFFF_FFFF_FFFF_FFFD, 2, 0);
    beat(68'hF_FFFF_FFFF_FFFF_FFFE, 3, 1);
    expect_line("small", 128'h19, 5, 1, 0);
    take_line("small");

    // 4: 68, 68 (overflows), 10 dropped with last
    @(posedge i_clk);
    #1;
    beat(68'hA_5A5A_5A5A_5A5A_5A5A, 68, 0);
    beat('1, 68, 0);
    beat('1, 10, 1);
    expect_line("ovf", 128'hA_5A5A_5A5A_5A5A_5A5A, 68, 2, 1);
    take_line("ovf");

    // 4b: overflow by one bit on the last beat goes straight to HOLD
    @(posedge i_clk);
    #1;
    beat(68'h1, 68, 0);
    beat('1, 61, 1);
    expect_line("ovf129", 128'h1, 68, 2, 1);
    take_line("ovf129");

    // 5: backpressure in HOLD with a beat waiting upstream
    @(posedge i_clk);
    #1;
    beat(68'hFA5, 8, 1);
    expect_line("hold", 128'hA5, 8, 1, 0);
    held = o_line;
    @(posedge i_clk);
    #1;
    i_valid  = 1'b1;
    i_data   = 68'h5;
    i_length = LEN_W'(4);
    i_last   = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge i_clk);
      check("hold_ready_low", CACHE_LINE'(o_ready), 0);
      check("hold_line_stable", o_line, held);
    end
    @(posedge i_clk);
    #1 i_ready = 1'b1;
    @(posedge i_clk);
    #1 i_ready = 1'b0;
    @(negedge i_clk);
    check("rel_valid_drop", CACHE_LINE'(o_valid), 0);
    check("rel_ready", CACHE_LINE'(o_ready), 1);
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    i_last  = 1'b0;
    expect_line("rel_next", 128'h5, 4, 1, 0);
    take_line("rel_next");

    // Zero-length last beat closes an empty line
    @(posedge i_clk);
    #1;
    beat('1, 0, 1);
    expect_line("empty", 128'h0, 0, 0, 0);
    take_line("empty");

    // 6: reset mid-line discards the partial line
    @(posedge i_clk);
    #1;
    beat('1, 10, 0);
    beat('1, 10, 0);
    i_reset = 1'b1;
    @(posedge i_clk);
    #1 i_reset = 1'b0;
    @(negedge i_clk);
    check("midrst_valid", CACHE_LINE'(o_valid), 0);
    @(posedge i_clk);
    #1;
    beat(68'hF_0123_4567_89AB_CDEF, 64, 1);
    expect_line("after_rst", 128'h0123_4567_89AB_CDEF, 64, 1, 0);
    take_line("after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
